// File: rtl/restoring_divider.sv
// Sequential 8-bit unsigned restoring divider (shift-and-subtract).
// Quotient = dividend / B, Remainder = dividend mod B, one quotient bit
// per SHIFT/TEST pair. Dividing by zero skips the iterations and returns
// Quotient=FF, Remainder=dividend with Dbz set.
module restoring_divider (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Load_B,
    input  logic [7:0] Din,
    output logic [7:0] Bval,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       Dbz
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StTest,
        StHold
    } state_t;

    state_t      r_state;
    logic [7:0]  r_b;
    logic [7:0]  r_q;
    logic [8:0]  r_r;
    logic [2:0]  r_cnt;
    logic        r_dbz;

    logic [8:0]  w_b_ext;
    logic [8:0]  w_diff;
    logic        w_ge;

    // Trial subtraction of the divisor from the partial remainder
    always_comb begin
        w_b_ext = {1'b0, r_b};
        w_diff  = r_r - w_b_ext;
        w_ge    = (r_r >= w_b_ext);
    end

    // Control FSM and datapath registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= StIdle;
            r_b     <= 8'd0;
            r_q     <= 8'd0;
            r_r     <= 9'd0;
            r_cnt   <= 3'd0;
            r_dbz   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // Load_B wins over Run in the same cycle
                    if (Load_B) begin
                        r_b <= Din;
                    end else if (Run) begin
                        if (r_b != 8'd0) begin
                            r_q     <= Din;
                            r_r     <= 9'd0;
                            r_cnt   <= 3'd0;
                            r_dbz   <= 1'b0;
                            r_state <= StShift;
                        end else begin
                            r_q     <= 8'hFF;
                            r_r     <= {1'b0, Din};
                            r_dbz   <= 1'b1;
                            r_state <= StHold;
                        end
                    end
                end
                StShift: begin
                    // Shift the next dividend bit into the partial remainder
                    r_r     <= {r_r[7:0], r_q[7]};
                    r_q     <= {r_q[6:0], 1'b0};
                    r_state <= StTest;
                end
                StTest: begin
                    if (w_ge) begin
                        r_r    <= w_diff;
                        r_q[0] <= 1'b1;
                    end else begin
                        r_q[0] <= 1'b0;
                    end
                    if (r_cnt == 3'd7) begin
                        r_state <= StHold;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= StShift;
                    end
                end
                StHold: begin
                    // Wait for Run release so one press is one operation
                    if (!Run) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs are registers or decodes of the state register
    always_comb begin
        Bval      = r_b;
        Quotient  = r_q;
        Remainder = r_r[7:0];
        Busy      = (r_state == StShift) || (r_state == StTest);
        Done      = (r_state == StHold);
        Dbz       = r_dbz;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vector table,
// hand-written multi-cycle corner cases and a randomized sweep against
// a plain-arithmetic reference model.
module tb_restoring_divider;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       Load_B;
    logic [7:0] Din;
    logic [7:0] Bval;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       Dbz;

    int checks;
    int failures;

    restoring_divider dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Load_B    (Load_B),
        .Din       (Din),
        .Bval      (Bval),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .Dbz       (Dbz)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int b;
        int dvd;
        int q;
        int r;
        int dbz;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Reference model: plain arithmetic
    task automatic model(input int b, input int dvd, output int q, output int r,
                         output int dbz);
        if (b == 0) begin
            q = 255; r = dvd; dbz = 1;
        end else begin
            q = dvd / b; r = dvd % b; dbz = 0;
        end
    endtask

    task automatic load_b(input int b);
        Load_B = 1'b1;
        Din    = 8'(b);
        @(negedge Clk);
        Load_B = 1'b0;
    endtask

    // Start from IDLE at a negedge; returns after Done (Run left high).
    // edges counts clock edges from the start edge inclusive.
    task automatic start_op(input int dvd, output int edges, output int busy_cnt);
        int cyc;
        Din = 8'(dvd);
        Run = 1'b1;
        @(negedge Clk);
        cyc      = 0;
        busy_cnt = 0;
        while (!Done && cyc < 40) begin
            if (Busy) busy_cnt++;
            @(negedge Clk);
            cyc++;
        end
        edges = cyc + 1;
        chk("done_within_bound", int'(Done), 1);
    endtask

    task automatic release_run();
        Run = 1'b0;
        @(negedge Clk);
        chk("idle_after_release", int'(Done), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int edges, busy_cnt, q, r, dbz, b, dvd;
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        Run      = 1'b0;
        Load_B   = 1'b0;
        Din      = 8'd0;

        vecs[0] = '{b: 7,   dvd: 100, q: 14,  r: 2,  dbz: 0};
        vecs[1] = '{b: 1,   dvd: 255, q: 255, r: 0,  dbz: 0};
        vecs[2] = '{b: 255, dvd: 255, q: 1,   r: 0,  dbz: 0};
        vecs[3] = '{b: 9,   dvd: 5,   q: 0,   r: 5,  dbz: 0};
        vecs[4] = '{b: 0,   dvd: 42,  q: 255, r: 42, dbz: 1};
        vecs[5] = '{b: 3,   dvd: 10,  q: 3,   r: 1,  dbz: 0};

        repeat (2) @(negedge Clk);
        chk("rst_bval", int'(Bval), 0);
        chk("rst_quot", int'(Quotient), 0);
        chk("rst_rem", int'(Remainder), 0);
        chk("rst_flags", int'({Busy, Done, Dbz}), 0);
        Reset = 1'b1;
        @(negedge Clk);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            load_b(vecs[i].b);
            chk("vec_bval", int'(Bval), vecs[i].b);
            start_op(vecs[i].dvd, edges, busy_cnt);
            chk("vec_quot", int'(Quotient), vecs[i].q);
            chk("vec_rem", int'(Remainder), vecs[i].r);
            chk("vec_dbz", int'(Dbz), vecs[i].dbz);
            chk("vec_latency", edges, (vecs[i].dbz != 0) ? 1 : 17);
            chk("vec_busy_cycles", busy_cnt, (vecs[i].dbz != 0) ? 0 : 16);
            release_run();
            chk("vec_quot_kept", int'(Quotient), vecs[i].q);
            chk("vec_dbz_kept", int'(Dbz), vecs[i].dbz);
        end

        // Run held long: one operation only, HOLD retained
        load_b(6);
        start_op(50, edges, busy_cnt);
        repeat (40) @(negedge Clk);
        chk("hold_done", int'(Done), 1);
        chk("hold_busy", int'(Busy), 0);
        chk("hold_quot", int'(Quotient), 8);
        chk("hold_rem", int'(Remainder), 2);
        release_run();
        start_op(51, edges, busy_cnt);
        chk("repress_quot", int'(Quotient), 8);
        chk("repress_rem", int'(Remainder), 3);
        chk("repress_latency", edges, 17);
        release_run();

        // Load_B during operation is ignored
        load_b(11);
        Din = 8'd200;
        Run = 1'b1;
        @(negedge Clk);
        repeat (3) @(negedge Clk);
        Load_B = 1'b1;
        Din    = 8'd0;
        repeat (6) @(negedge Clk);
        chk("loadb_busy_bval", int'(Bval), 11);
        Load_B = 1'b0;
        repeat (20) @(negedge Clk);
        chk("loadb_busy_done", int'(Done), 1);
        chk("loadb_busy_quot", int'(Quotient), 18);
        chk("loadb_busy_rem", int'(Remainder), 2);
        release_run();

        // Load_B and Run together: load wins, start next cycle with new B
        Load_B = 1'b1;
        Run    = 1'b1;
        Din    = 8'd13;
        @(negedge Clk);
        chk("both_bval", int'(Bval), 13);
        chk("both_no_start", int'(Busy), 0);
        Load_B = 1'b0;
        start_op(100, edges, busy_cnt);
        chk("both_quot", int'(Quotient), 7);
        chk("both_rem", int'(Remainder), 9);
        release_run();

        // Asynchronous reset mid-operation
        load_b(7);
        Din = 8'd100;
        Run = 1'b1;
        repeat (8) @(negedge Clk);
        Run = 1'b0;
        #1 Reset = 1'b0;
        #1;
        chk("arst_bval", int'(Bval), 0);
        chk("arst_quot", int'(Quotient), 0);
        chk("arst_rem", int'(Remainder), 0);
        chk("arst_flags", int'({Busy, Done, Dbz}), 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("arst_idle", int'({Busy, Done}), 0);
        load_b(7);
        start_op(100, edges, busy_cnt);
        chk("arst_quot_after", int'(Quotient), 14);
        chk("arst_rem_after", int'(Remainder), 2);
        release_run();

        // Randomized sweep against the reference model
        for (int n = 0; n < 1500; n++) begin
            b   = (n % 50 == 0) ? 0 : int'($urandom_range(255, 0));
            dvd = int'($urandom_range(255, 0));
            model(b, dvd, q, r, dbz);
            load_b(b);
            start_op(dvd, edges, busy_cnt);
            checks++;
            if (int'(Quotient) != q || int'(Remainder) != r || int'(Dbz) != dbz ||
                edges != ((dbz != 0) ? 1 : 17)) begin
                failures++;
                $display("FAIL rand b=%0d dvd=%0d got q=%0d r=%0d dbz=%0d edges=%0d exp q=%0d r=%0d dbz=%0d",
                         b, dvd, Quotient, Remainder, Dbz, edges, q, r, dbz);
            end
            if (dbz == 0) begin
                checks++;
                if (int'(Quotient) * int'(Bval) + int'(Remainder) != dvd ||
                    int'(Remainder) >= int'(Bval)) begin
                    failures++;
                    $display("FAIL invariant b=%0d dvd=%0d got q=%0d r=%0d", int'(Bval), dvd,
                             Quotient, Remainder);
                end
            end
            release_run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
